uart_tx: RTL and testbench

Byte-wide UART transmitter, 8N1 framing, LSB first. It is the transmit-side companion of the team's UART receiver and uses the same bit period: 2604 clocks per bit by default. A host pulses `trmt` with a byte. The block serializes the start bit, 8 data bits and the stop bit on `TX`, then raises `tx_done`. It sits between command/response logic and the off-chip serial line.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_tx_if.sv | 36 +++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_tx.sv | 92 +++++++++
 tb/tb_uart_tx.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and the receiver.
// Contents:
//   tx_state_t       - transmitter FSM states (IDLE, TRANSMIT)
//   BAUD_DIV_DEFAULT - default clocks per bit period (2604)
//   FRAME_BITS       - bits per frame including start and stop
//   build_frame()    - forms the shift-register image of one frame
// Build option: UART_TX_PARITY_EN inserts an even-parity bit between the
// last data bit and the stop bit, giving 11-bit frames instead of 10.
package uart_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } tx_state_t;

    localparam int BAUD_DIV_DEFAULT = 2604;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Frame image, bit 0 goes out first: start(0), data LSB..MSB,
    // [even parity], stop(1).
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^data, data, 1'b0};
`else
        return {1'b1, data, 1'b0};
`endif
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side interface of the UART transmitter.
// Signals:
//   trmt      - start-transmit strobe (host -> uart), sampled only in IDLE
//   tx_data   - byte to send (host -> uart), captured when trmt is accepted
//   tx_busy   - frame in flight (uart -> host)
//   tx_done   - sticky frame-complete flag (uart -> host)
//   state_dbg - current FSM state for observation (uart -> host)
// Handshake: a frame is accepted on any rising clk edge where trmt=1 and
// tx_busy=0; trmt while tx_busy=1 is dropped, never queued. tx_done rises
// on the edge that ends the frame and clears on the next acceptance.
interface uart_tx_if;
    import uart_pkg::*;

    logic      trmt;
    logic [7:0] tx_data;
    logic      tx_busy;
    logic      tx_done;
    tx_state_t state_dbg;

    modport master (
        output trmt,
        output tx_data,
        input  tx_busy,
        input  tx_done,
        input  state_dbg
    );

    modport slave (
        input  trmt,
        input  tx_data,
        output tx_busy,
        output tx_done,
        output state_dbg
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   clr      - synchronous clear of the period counter (wins over en)
//   en       - count enable
//   bit_tick - one-cycle pulse on the last clock of each bit period
// The counter runs 0..BAUD_DIV-1 and wraps on bit_tick, so it never
// exceeds BAUD_DIV-1.
module uart_baud_gen #(
    parameter int BAUD_DIV = uart_pkg::BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_tick
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] baud_cnt;

    assign bit_tick = en && (baud_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
        end else if (clr) begin
            baud_cnt <= '0;
        end else if (en) begin
            baud_cnt <= bit_tick ? '0 : baud_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter, LSB first, 8N1 by default.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   host - uart_tx_if.slave: trmt, tx_data in; tx_busy, tx_done, state_dbg out
//   TX   - serial line, driven straight from shift_reg[0], idles high
// Build option: UART_TX_PARITY_EN adds an even-parity bit (11-bit frames);
// ports are the same in both builds.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave host,
    output logic     TX
);

    tx_state_t             state;
    tx_state_t             state_nxt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [3:0]            bit_cnt;
    logic                  tx_done_r;
    logic                  load;
    logic                  bit_tick;
    logic                  last_bit;

    // Acceptance only happens in IDLE, so trmt during a frame, including
    // the cycle the frame completes, is ignored.
    assign load     = (state == IDLE) && host.trmt;
    assign last_bit = bit_tick && (bit_cnt == 4'(FRAME_BITS - 1));

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      (load),
        .en       (state == TRANSMIT),
        .bit_tick (bit_tick)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (host.trmt) state_nxt = TRANSMIT;
            TRANSMIT: if (last_bit)  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        host.tx_busy   = (state == TRANSMIT);
        host.tx_done   = tx_done_r;
        host.state_dbg = state;
    end

    // Shifting in ones means the line is already high once the stop bit
    // has gone out, and stays high in IDLE without extra muxing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '1;
            bit_cnt   <= '0;
            tx_done_r <= 1'b0;
        end else if (load) begin
            shift_reg <= build_frame(host.tx_data);
            bit_cnt   <= '0;
            tx_done_r <= 1'b0;
        end else if (bit_tick) begin
            shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
            bit_cnt   <= bit_cnt + 4'd1;
            if (last_bit) begin
                tx_done_r <= 1'b1;
            end
        end
    end

    assign TX = shift_reg[0];

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BAUD_DIV=16. Frame expectations are
// hand-computed bit images (bit k = TX level during bit period k).
module tb_uart_tx;

    localparam int BD = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = FB * BD;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] exp_8n1;
        logic [10:0] exp_par;
        int          glitch_at;
    } vec_t;

    logic clk;
    logic rst;
    logic TX;

    uart_tx_if bus ();

    uart_tx #(
        .BAUD_DIV (BD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .host (bus),
        .TX   (TX)
    );

    int checks   = 0;
    int failures = 0;
    logic [10:0] exp_q[$];
    vec_t vecs[8];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver: one frame ----------------
    // Accepts a frame, samples TX mid-period, checks busy/done timing.
    // glitch_at > 0 pulses trmt with 0xFF that many cycles into the frame.
    task automatic run_frame(input string tag, input logic [7:0] data,
                             input logic [10:0] exp_bits, input int glitch_at);
        logic [10:0] got;
        logic [10:0] exp;
        int done_at;
        int done_rises;
        int busy_err;
        logic prev_done;
        got        = '0;
        done_at    = -1;
        done_rises = 0;
        busy_err   = 0;
        exp_q.push_back(exp_bits);
        bus.tx_data = data;
        bus.trmt    = 1'b1;
        @(posedge clk); #1;
        bus.trmt = 1'b0;
        check({tag, "_accept_busy"}, 32'(bus.tx_busy), 32'd1);
        check({tag, "_accept_done_clr"}, 32'(bus.tx_done), 32'd0);
        prev_done = bus.tx_done;
        for (int i = 1; i <= FL + BD; i++) begin
            @(posedge clk); #1;
            if ((i % BD) == BD / 2 && (i / BD) < FB) got[i / BD] = TX;
            if (bus.tx_done && !prev_done) begin
                done_rises++;
                if (done_at < 0) done_at = i;
            end
            prev_done = bus.tx_done;
            if (i < FL && !bus.tx_busy) busy_err++;
            if (i >= FL && bus.tx_busy) busy_err++;
            if (glitch_at > 0 && i == glitch_at) begin
                bus.trmt    = 1'b1;
                bus.tx_data = 8'hFF;
            end else if (glitch_at > 0 && i == glitch_at + 1) begin
                bus.trmt = 1'b0;
            end
        end
        exp = exp_q.pop_front();
        check({tag, "_bits"}, 32'(got), 32'(exp));
        check({tag, "_done_latency"}, 32'(done_at), 32'(FL));
        check({tag, "_done_rises"}, 32'(done_rises), 32'd1);
        check({tag, "_busy_window"}, 32'(busy_err), 32'd0);
        check({tag, "_done_sticky"}, 32'(bus.tx_done), 32'd1);
        check({tag, "_line_idle"}, 32'(TX), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [10:0] exp_bits;
        logic [10:0] got1;
        logic [10:0] got2;
        int err;
        int fall_at;
        int j;

        vecs[0] = '{8'hA5, 11'h34A, 11'h54A, 0};
        vecs[1] = '{8'h07, 11'h20E, 11'h60E, 0};
        vecs[2] = '{8'h00, 11'h200, 11'h400, 0};
        vecs[3] = '{8'hFF, 11'h3FE, 11'h5FE, 0};
        vecs[4] = '{8'h5A, 11'h2B4, 11'h4B4, 0};
        vecs[5] = '{8'h80, 11'h300, 11'h700, 0};
        vecs[6] = '{8'h01, 11'h202, 11'h602, 0};
        vecs[7] = '{8'hA5, 11'h34A, 11'h54A, 40};

        rst         = 1'b1;
        bus.trmt    = 1'b0;
        bus.tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", 32'(TX), 32'd1);
        check("reset_busy", 32'(bus.tx_busy), 32'd0);
        check("reset_done", 32'(bus.tx_done), 32'd0);
        rst = 1'b0;

        // Idle with trmt low: line stays quiet.
        err = 0;
        for (int i = 0; i < 5 * BD; i++) begin
            @(posedge clk); #1;
            if (TX !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) err++;
        end
        check("idle_quiet", 32'(err), 32'd0);

        // Table of single frames.
        for (int v = 0; v < 8; v++) begin
`ifdef UART_TX_PARITY_EN
            exp_bits = vecs[v].exp_par;
`else
            exp_bits = vecs[v].exp_8n1;
`endif
            run_frame($sformatf("vec%0d", v), vecs[v].data, exp_bits, vecs[v].glitch_at);
        end

        // Back-to-back with trmt held: 0x55 then 0x3C.
        bus.tx_data = 8'h55;
        bus.trmt    = 1'b1;
        @(posedge clk); #1;
        bus.tx_data = 8'h3C;
        check("b2b_start1", 32'(TX), 32'd0);
        got1    = '0;
        got2    = '0;
        fall_at = -1;
        for (int i = 1; i <= 2 * FL + 1; i++) begin
            @(posedge clk); #1;
            if ((i % BD) == BD / 2 && (i / BD) < FB) got1[i / BD] = TX;
            j = i - (FL + 1);
            if (j > 0 && (j % BD) == BD / 2 && (j / BD) < FB) got2[j / BD] = TX;
            if (i >= FL && TX == 1'b0 && fall_at < 0) fall_at = i;
            if (i == FL)     check("b2b_done1", 32'(bus.tx_done), 32'd1);
            if (i == FL + 1) begin
                check("b2b_done_clr", 32'(bus.tx_done), 32'd0);
                bus.trmt = 1'b0;
            end
        end
`ifdef UART_TX_PARITY_EN
        check("b2b_bits1", 32'(got1), 32'h4AA);
        check("b2b_bits2", 32'(got2), 32'h478);
`else
        check("b2b_bits1", 32'(got1), 32'h2AA);
        check("b2b_bits2", 32'(got2), 32'h278);
`endif
        check("b2b_gap", 32'(fall_at), 32'(FL + 1));
        check("b2b_done2", 32'(bus.tx_done), 32'd1);

        // Reset in the middle of data bit 2 of a 0x00 frame.
        bus.tx_data = 8'h00;
        bus.trmt    = 1'b1;
        @(posedge clk); #1;
        bus.trmt = 1'b0;
        repeat (3 * BD + 5) @(posedge clk);
        #1;
        check("rst_mid_tx_low", 32'(TX), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_tx", 32'(TX), 32'd1);
        check("rst_async_busy", 32'(bus.tx_busy), 32'd0);
        check("rst_async_done", 32'(bus.tx_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        err = 0;
        for (int i = 0; i < 2 * BD; i++) begin
            @(posedge clk); #1;
            if (TX !== 1'b1 || bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b0) err++;
        end
        check("rst_after_quiet", 32'(err), 32'd0);
`ifdef UART_TX_PARITY_EN
        run_frame("post_rst", 8'hA5, 11'h54A, 0);
`else
        run_frame("post_rst", 8'hA5, 11'h34A, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
